// File: rtl/axi_slice_dc_pkg.sv
`default_nettype none
// ============================================================================
// axi_slice_dc_pkg : shared types and sizing helpers for the dual-clock slice
// Revision: 1.0
// ============================================================================
package axi_slice_dc_pkg;

  typedef enum logic [2:0] {
    ST_ACTIVE = 3'd0,
    ST_DRAIN  = 3'd1,
    ST_DOWN   = 3'd2,
    ST_ISO    = 3'd3,
    ST_WAKE   = 3'd4
  } pwr_state_e;

  // Width able to hold 0..max inclusive.
  function automatic int cnt_width(input int max);
    return $clog2(max + 1);
  endfunction

  // Width of a 0..n-1 cycle timer, never below one bit.
  function automatic int timer_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi_slice_dc_outst_cnt.sv
`default_nettype none
// ============================================================================
// axi_slice_dc_outst_cnt : saturating up/down outstanding-transaction counter
// Revision: 1.0
// ============================================================================
module axi_slice_dc_outst_cnt #(
  parameter int       MAX        = 8,
  parameter int       W          = 4,
  parameter bit       SIGNED_CNT = 1'b0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         i_clr,
  input  logic         i_inc,
  input  logic         i_dec,
  output logic [W-1:0] o_cnt,
  output logic         o_err
);

  // Lower bound is -MAX in two's complement for the signed variant.
  localparam logic [W-1:0] C_MAX = W'(MAX);
  localparam logic [W-1:0] C_MIN = SIGNED_CNT ? W'(-MAX) : W'(0);

  logic [W-1:0] r_cnt;
  logic         w_inc_only;
  logic         w_dec_only;
  logic         w_at_max;
  logic         w_at_min;

  assign w_inc_only = i_inc & ~i_dec;
  assign w_dec_only = i_dec & ~i_inc;
  assign w_at_max   = (r_cnt == C_MAX);
  assign w_at_min   = (r_cnt == C_MIN);

  assign o_err = ~i_clr & ((w_inc_only & w_at_max) | (w_dec_only & w_at_min));
  assign o_cnt = r_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i || i_clr) begin
      r_cnt <= '0;
    end else if (w_inc_only && !w_at_max) begin
      r_cnt <= r_cnt + W'(1);
    end else if (w_dec_only && !w_at_min) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/axi_slice_dc_pwr_ctrl.sv
`default_nettype none
// ============================================================================
// axi_slice_dc_pwr_ctrl : drain / clock-down / isolation sequencer for the
//                         master side of the dual-clock AXI slice
// Revision: 1.0
// ============================================================================
module axi_slice_dc_pwr_ctrl
  import axi_slice_dc_pkg::*;
#(
  parameter int MAX_OUTST    = 8,
  parameter int DRAIN_CYCLES = 256,
  parameter int WAKE_CYCLES  = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pwr_down_req_i,
  output logic pwr_down_ack_o,
  output logic timeout_o,
  output logic wake_req_o,
  input  logic incoming_req_i,
  input  logic aw_hs_i,
  input  logic ar_hs_i,
  input  logic w_last_hs_i,
  input  logic b_hs_i,
  input  logic r_last_hs_i,
  output logic clock_down_o,
  output logic isolate_o,
  output logic cnt_err_o
);

  localparam int CNT_W = cnt_width(MAX_OUTST);
  localparam int DT_W  = timer_width(DRAIN_CYCLES);
  localparam int WT_W  = timer_width(WAKE_CYCLES);

  localparam logic [DT_W-1:0] C_DRAIN_LAST = DT_W'(DRAIN_CYCLES - 1);
  localparam logic [WT_W-1:0] C_WAKE_LAST  = WT_W'(WAKE_CYCLES - 1);

  pwr_state_e       r_state;
  pwr_state_e       w_state_nxt;
  logic [DT_W-1:0]  r_drain_tmr;
  logic [WT_W-1:0]  r_wake_tmr;

  logic [CNT_W-1:0] w_wr_cnt;
  logic [CNT_W-1:0] w_rd_cnt;
  logic [CNT_W:0]   w_w_bal;
  logic             w_wr_err;
  logic             w_rd_err;
  logic             w_wb_err;
  logic             w_cnt_clr;
  logic             w_idle;

  logic             r_ack;
  logic             r_timeout;
  logic             r_wake_req;
  logic             r_clock_down;
  logic             r_isolate;
  logic             r_cnt_err;

  logic             w_ack_nxt;
  logic             w_timeout_nxt;
  logic             w_wake_req_nxt;
  logic             w_clock_down_nxt;
  logic             w_isolate_nxt;
  logic             w_cnt_err_nxt;

  // Forced isolation abandons whatever was in flight; start from a clean slate.
  assign w_cnt_clr = (w_state_nxt == ST_ISO) && (r_state != ST_ISO);

  axi_slice_dc_outst_cnt #(
    .MAX        (MAX_OUTST),
    .W          (CNT_W),
    .SIGNED_CNT (1'b0)
  ) u_wr_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .i_clr (w_cnt_clr),
    .i_inc (aw_hs_i),
    .i_dec (b_hs_i),
    .o_cnt (w_wr_cnt),
    .o_err (w_wr_err)
  );

  axi_slice_dc_outst_cnt #(
    .MAX        (MAX_OUTST),
    .W          (CNT_W),
    .SIGNED_CNT (1'b0)
  ) u_rd_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .i_clr (w_cnt_clr),
    .i_inc (ar_hs_i),
    .i_dec (r_last_hs_i),
    .o_cnt (w_rd_cnt),
    .o_err (w_rd_err)
  );

  // W data may legally run ahead of its AW, so this balance can go negative.
  axi_slice_dc_outst_cnt #(
    .MAX        (MAX_OUTST),
    .W          (CNT_W + 1),
    .SIGNED_CNT (1'b1)
  ) u_w_bal (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .i_clr (w_cnt_clr),
    .i_inc (aw_hs_i),
    .i_dec (w_last_hs_i),
    .o_cnt (w_w_bal),
    .o_err (w_wb_err)
  );

  assign w_idle = (w_wr_cnt == '0) && (w_rd_cnt == '0) && (w_w_bal == '0) && !incoming_req_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_ACTIVE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_ACTIVE: begin
        if (pwr_down_req_i) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!pwr_down_req_i)                w_state_nxt = ST_ACTIVE;
        else if (w_idle)                    w_state_nxt = ST_DOWN;
        else if (r_drain_tmr == C_DRAIN_LAST) w_state_nxt = ST_ISO;
      end
      ST_DOWN, ST_ISO: begin
        if (!pwr_down_req_i) w_state_nxt = ST_WAKE;
      end
      ST_WAKE: begin
        if (r_wake_tmr == C_WAKE_LAST) w_state_nxt = ST_ACTIVE;
      end
      default: w_state_nxt = ST_ACTIVE;
    endcase
  end

  // Timers idle at zero outside their state, so entry always starts from zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_drain_tmr <= '0;
      r_wake_tmr  <= '0;
    end else begin
      r_drain_tmr <= (r_state == ST_DRAIN) ? r_drain_tmr + DT_W'(1) : '0;
      r_wake_tmr  <= (r_state == ST_WAKE)  ? r_wake_tmr  + WT_W'(1) : '0;
    end
  end

  always_comb begin
    w_clock_down_nxt = (w_state_nxt == ST_DOWN) || (w_state_nxt == ST_ISO) || (w_state_nxt == ST_WAKE);
    w_isolate_nxt    = (w_state_nxt == ST_ISO);
    w_ack_nxt        = (w_state_nxt == ST_DOWN) || (w_state_nxt == ST_ISO);
    w_wake_req_nxt   = incoming_req_i && ((r_state == ST_DOWN) || (r_state == ST_ISO));
    w_cnt_err_nxt    = r_cnt_err | w_wr_err | w_rd_err | w_wb_err;
    w_timeout_nxt    = r_timeout;
    if (w_state_nxt == ST_ISO) begin
      w_timeout_nxt = 1'b1;
    end else if ((w_state_nxt == ST_DRAIN) && (r_state != ST_DRAIN)) begin
      w_timeout_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ack        <= 1'b0;
      r_timeout    <= 1'b0;
      r_wake_req   <= 1'b0;
      r_clock_down <= 1'b0;
      r_isolate    <= 1'b0;
      r_cnt_err    <= 1'b0;
    end else begin
      r_ack        <= w_ack_nxt;
      r_timeout    <= w_timeout_nxt;
      r_wake_req   <= w_wake_req_nxt;
      r_clock_down <= w_clock_down_nxt;
      r_isolate    <= w_isolate_nxt;
      r_cnt_err    <= w_cnt_err_nxt;
    end
  end

  assign pwr_down_ack_o = r_ack;
  assign timeout_o      = r_timeout;
  assign wake_req_o     = r_wake_req;
  assign clock_down_o   = r_clock_down;
  assign isolate_o      = r_isolate;
  assign cnt_err_o      = r_cnt_err;

endmodule
`default_nettype wire

// File: tb/tb_axi_slice_dc_pwr_ctrl.sv
`default_nettype none
// ============================================================================
// tb_axi_slice_dc_pwr_ctrl : directed self-checking bench for the sequencer
// Revision: 1.0
// ============================================================================
module tb_axi_slice_dc_pwr_ctrl;

  logic clk_i = 1'b0;
  logic rst_i;
  logic pwr_down_req_i, incoming_req_i;
  logic aw_hs_i, ar_hs_i, w_last_hs_i, b_hs_i, r_last_hs_i;
  logic pwr_down_ack_o, timeout_o, wake_req_o, clock_down_o, isolate_o, cnt_err_o;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  axi_slice_dc_pwr_ctrl #(
    .MAX_OUTST    (8),
    .DRAIN_CYCLES (16),
    .WAKE_CYCLES  (4)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .pwr_down_req_i (pwr_down_req_i),
    .pwr_down_ack_o (pwr_down_ack_o),
    .timeout_o      (timeout_o),
    .wake_req_o     (wake_req_o),
    .incoming_req_i (incoming_req_i),
    .aw_hs_i        (aw_hs_i),
    .ar_hs_i        (ar_hs_i),
    .w_last_hs_i    (w_last_hs_i),
    .b_hs_i         (b_hs_i),
    .r_last_hs_i    (r_last_hs_i),
    .clock_down_o   (clock_down_o),
    .isolate_o      (isolate_o),
    .cnt_err_o      (cnt_err_o)
  );

  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic pulse(input logic aw, input logic ar, input logic wl, input logic b, input logic rl);
    aw_hs_i = aw; ar_hs_i = ar; w_last_hs_i = wl; b_hs_i = b; r_last_hs_i = rl;
    tick();
    aw_hs_i = 0; ar_hs_i = 0; w_last_hs_i = 0; b_hs_i = 0; r_last_hs_i = 0;
  endtask

  task automatic go_active();
    pwr_down_req_i = 0;
    repeat (5) tick();
  endtask

  task automatic test_reset();
    rst_i = 1;
    repeat (2) tick();
    rst_i = 0;
    checks++;
    if ({pwr_down_ack_o, timeout_o, wake_req_o, clock_down_o, isolate_o, cnt_err_o} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 000000",
               {pwr_down_ack_o, timeout_o, wake_req_o, clock_down_o, isolate_o, cnt_err_o});
    end
  endtask

  task automatic test_idle_req();
    pwr_down_req_i = 1;
    tick();
    checks++;
    if ({clock_down_o, pwr_down_ack_o} !== 2'b00) begin
      errors++; $display("FAIL idle_drain_cycle: got cd/ack=%b expected 00", {clock_down_o, pwr_down_ack_o});
    end
    tick();
    checks++;
    if ({clock_down_o, pwr_down_ack_o, isolate_o} !== 3'b110) begin
      errors++; $display("FAIL idle_down: got cd/ack/iso=%b expected 110", {clock_down_o, pwr_down_ack_o, isolate_o});
    end
  endtask

  task automatic test_wake();
    checks++;
    if (wake_req_o !== 1'b0) begin
      errors++; $display("FAIL wake_req_quiet: got %b expected 0", wake_req_o);
    end
    incoming_req_i = 1;
    tick();
    checks++;
    if (wake_req_o !== 1'b1) begin
      errors++; $display("FAIL wake_req_set: got %b expected 1", wake_req_o);
    end
    incoming_req_i = 0;
    tick();
    checks++;
    if (wake_req_o !== 1'b0) begin
      errors++; $display("FAIL wake_req_clear: got %b expected 0", wake_req_o);
    end
    pwr_down_req_i = 0;
    tick();
    checks++;
    if ({clock_down_o, pwr_down_ack_o} !== 2'b10) begin
      errors++; $display("FAIL wake_entry: got cd/ack=%b expected 10", {clock_down_o, pwr_down_ack_o});
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({clock_down_o, pwr_down_ack_o} !== 2'b10) begin
        errors++; $display("FAIL wake_hold%0d: got cd/ack=%b expected 10", i, {clock_down_o, pwr_down_ack_o});
      end
    end
    tick();
    checks++;
    if ({clock_down_o, pwr_down_ack_o} !== 2'b00) begin
      errors++; $display("FAIL wake_done: got cd/ack=%b expected 00", {clock_down_o, pwr_down_ack_o});
    end
  endtask

  task automatic test_drain();
    pulse(1, 0, 0, 0, 0);
    pulse(1, 0, 0, 0, 0);
    pulse(0, 0, 1, 0, 0);
    pulse(0, 0, 1, 0, 0);
    pulse(0, 1, 0, 0, 0);
    pwr_down_req_i = 1;
    tick();
    tick();
    checks++;
    if (clock_down_o !== 1'b0) begin
      errors++; $display("FAIL drain_wait_all: got cd=%b expected 0", clock_down_o);
    end
    pulse(0, 0, 0, 1, 0);
    pulse(0, 0, 0, 1, 0);
    checks++;
    if (clock_down_o !== 1'b0) begin
      errors++; $display("FAIL drain_wait_r: got cd=%b expected 0", clock_down_o);
    end
    pulse(0, 0, 0, 0, 1);
    checks++;
    if (clock_down_o !== 1'b0) begin
      errors++; $display("FAIL drain_last_r_cycle: got cd=%b expected 0", clock_down_o);
    end
    tick();
    checks++;
    if ({clock_down_o, isolate_o, timeout_o} !== 3'b100) begin
      errors++; $display("FAIL drain_down: got cd/iso/to=%b expected 100", {clock_down_o, isolate_o, timeout_o});
    end
    go_active();
  endtask

  task automatic test_timeout();
    pulse(0, 1, 0, 0, 0);
    pwr_down_req_i = 1;
    repeat (16) tick();
    checks++;
    if ({clock_down_o, isolate_o} !== 2'b00) begin
      errors++; $display("FAIL timeout_early: got cd/iso=%b expected 00", {clock_down_o, isolate_o});
    end
    tick();
    checks++;
    if ({clock_down_o, isolate_o, timeout_o, pwr_down_ack_o} !== 4'b1111) begin
      errors++; $display("FAIL timeout_iso: got cd/iso/to/ack=%b expected 1111",
                         {clock_down_o, isolate_o, timeout_o, pwr_down_ack_o});
    end
    go_active();
    checks++;
    if ({clock_down_o, timeout_o} !== 2'b01) begin
      errors++; $display("FAIL timeout_sticky: got cd/to=%b expected 01", {clock_down_o, timeout_o});
    end
    pwr_down_req_i = 1;
    tick();
    checks++;
    if (timeout_o !== 1'b0) begin
      errors++; $display("FAIL timeout_clear_on_drain: got %b expected 0", timeout_o);
    end
    tick();
    checks++;
    if (clock_down_o !== 1'b1) begin
      errors++; $display("FAIL iso_counters_cleared: got cd=%b expected 1", clock_down_o);
    end
    go_active();
  endtask

  task automatic test_abort();
    incoming_req_i = 1;
    pwr_down_req_i = 1;
    tick();
    tick();
    checks++;
    if ({clock_down_o, pwr_down_ack_o} !== 2'b00) begin
      errors++; $display("FAIL abort_in_drain: got cd/ack=%b expected 00", {clock_down_o, pwr_down_ack_o});
    end
    pwr_down_req_i = 0;
    repeat (20) tick();
    checks++;
    if ({clock_down_o, isolate_o, timeout_o} !== 3'b000) begin
      errors++; $display("FAIL abort_active: got cd/iso/to=%b expected 000", {clock_down_o, isolate_o, timeout_o});
    end
    incoming_req_i = 0;
  endtask

  task automatic test_simultaneous();
    pulse(1, 0, 0, 0, 0);
    pulse(0, 0, 1, 0, 0);
    pulse(1, 0, 1, 1, 0);
    pwr_down_req_i = 1;
    tick();
    tick();
    checks++;
    if (clock_down_o !== 1'b0) begin
      errors++; $display("FAIL simul_hold_one: got cd=%b expected 0", clock_down_o);
    end
    pulse(0, 0, 0, 1, 0);
    checks++;
    if (clock_down_o !== 1'b0) begin
      errors++; $display("FAIL simul_last_b_cycle: got cd=%b expected 0", clock_down_o);
    end
    tick();
    checks++;
    if ({clock_down_o, cnt_err_o} !== 2'b10) begin
      errors++; $display("FAIL simul_down: got cd/err=%b expected 10", {clock_down_o, cnt_err_o});
    end
    go_active();
  endtask

  task automatic test_saturate();
    repeat (8) pulse(1, 0, 0, 0, 0);
    checks++;
    if (cnt_err_o !== 1'b0) begin
      errors++; $display("FAIL sat_at_max_no_err: got %b expected 0", cnt_err_o);
    end
    pulse(1, 0, 0, 0, 0);
    checks++;
    if (cnt_err_o !== 1'b1) begin
      errors++; $display("FAIL sat_overflow_err: got %b expected 1", cnt_err_o);
    end
    repeat (8) pulse(0, 0, 1, 0, 0);
    repeat (7) pulse(0, 0, 0, 1, 0);
    pwr_down_req_i = 1;
    tick();
    tick();
    checks++;
    if (clock_down_o !== 1'b0) begin
      errors++; $display("FAIL sat_held_eight: got cd=%b expected 0", clock_down_o);
    end
    pulse(0, 0, 0, 1, 0);
    tick();
    checks++;
    if ({clock_down_o, cnt_err_o} !== 2'b11) begin
      errors++; $display("FAIL sat_drained: got cd/err=%b expected 11", {clock_down_o, cnt_err_o});
    end
    go_active();
  endtask

  task automatic test_reset_in_iso();
    pulse(0, 1, 0, 0, 0);
    pwr_down_req_i = 1;
    repeat (17) tick();
    checks++;
    if (isolate_o !== 1'b1) begin
      errors++; $display("FAIL rst_reach_iso: got iso=%b expected 1", isolate_o);
    end
    rst_i = 1;
    pwr_down_req_i = 0;
    tick();
    rst_i = 0;
    checks++;
    if ({pwr_down_ack_o, timeout_o, wake_req_o, clock_down_o, isolate_o, cnt_err_o} !== 6'b0) begin
      errors++;
      $display("FAIL rst_in_iso_outputs: got %b expected 000000",
               {pwr_down_ack_o, timeout_o, wake_req_o, clock_down_o, isolate_o, cnt_err_o});
    end
    pwr_down_req_i = 1;
    tick();
    tick();
    checks++;
    if (clock_down_o !== 1'b1) begin
      errors++; $display("FAIL rst_counters_zero: got cd=%b expected 1", clock_down_o);
    end
    go_active();
  endtask

  initial begin
    rst_i = 1; pwr_down_req_i = 0; incoming_req_i = 0;
    aw_hs_i = 0; ar_hs_i = 0; w_last_hs_i = 0; b_hs_i = 0; r_last_hs_i = 0;
    @(negedge clk_i);
    test_reset();
    test_idle_req();
    test_wake();
    test_drain();
    test_timeout();
    test_abort();
    test_simultaneous();
    test_saturate();
    test_reset_in_iso();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
